// File: rtl/ram_banked_clr_pkg.sv
// Shared definitions for the banked, self-clearing RAM: FSM state encoding
// and the bank-count helper used to size the bank array.
package ram_banked_clr_pkg;

  // Clear-engine states. CLEAR doubles as the busy indication.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Number of banks for a given total/in-bank address split.
  function automatic int nbanks(input int addr_w, input int bank_addr_w);
    return 1 << (addr_w - bank_addr_w);
  endfunction

endpackage

// File: rtl/ram_banked_clr_bank.sv
// One RAM bank: DATA_W x 2**WORD_W words, combinational read, synchronous
// write. Contents are not reset; the top-level clear engine zeroes them.
module ram_bank
  import ram_banked_clr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WORD_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WORD_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int WORDS = 1 << WORD_W;

  logic [DATA_W-1:0] mem [WORDS];

  // Storage write; only the bank selected by the top sees we=1.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read; a same-cycle write becomes visible after the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_banked_clr.sv
// Banked Hack-style RAM with a built-in clear engine. After reset, or on a
// clear request, the engine walks every address writing zero; while it runs
// the port reads 0, port writes are discarded and reported on drop.
module ram_banked_clr
  import ram_banked_clr_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int BANK_ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              drop
);

  localparam int NBANKS = nbanks(ADDR_W, BANK_ADDR_W);
  // Bank-select width; kept at least 1 so the single-bank build still has
  // a legal vector, even though the select is then constant.
  localparam int SEL_W  = (ADDR_W > BANK_ADDR_W) ? (ADDR_W - BANK_ADDR_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e             state_reg;
  logic [ADDR_W-1:0]  clr_ptr_reg;
  logic               drop_reg;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [SEL_W-1:0]   wr_sel;
  logic [DATA_W-1:0]  rd_word;

  logic [NBANKS-1:0]  bank_we;
  logic [DATA_W-1:0]  bank_rdata [NBANKS];

  // busy is a direct decode of the state register, so it is glitch-free and
  // is 1 in exactly the cycles spent in CLEAR.
  assign busy = (state_reg == ST_CLEAR);
  assign drop = drop_reg;

  // Clear-engine FSM plus the registered drop pulse. A clear request always
  // restarts the walk from address 0, including on the walk's last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
      drop_reg    <= 1'b0;
    end else begin
      drop_reg <= load & busy;
      case (state_reg)
        ST_CLEAR: begin
          if (clear) begin
            clr_ptr_reg <= '0;
          end else if (clr_ptr_reg == LAST_ADDR) begin
            clr_ptr_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          // A load on this same edge still lands, since wr_en is driven by
          // the port while busy=0; the walk then overwrites it.
          if (clear) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
          end
        end
        default: begin
          state_reg   <= ST_CLEAR;
          clr_ptr_reg <= '0;
        end
      endcase
    end
  end

  // Bank write mux: the clear engine owns the write path while busy.
  always_comb begin
    wr_en   = load;
    wr_addr = address;
    wr_data = in;
    if (busy) begin
      wr_en   = 1'b1;
      wr_addr = clr_ptr_reg;
      wr_data = '0;
    end
  end

  // Bank selection from the upper address bits; a single-bank build has no
  // upper bits, so the select collapses to the only bank.
  generate
    if (NBANKS > 1) begin : g_multi_bank
      assign wr_sel  = wr_addr[ADDR_W-1:BANK_ADDR_W];
      assign rd_word = bank_rdata[address[ADDR_W-1:BANK_ADDR_W]];
    end else begin : g_single_bank
      assign wr_sel  = '0;
      assign rd_word = bank_rdata[0];
    end
  endgenerate

  // One bank per upper-address value; only the addressed bank is enabled.
  generate
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      assign bank_we[gi] = wr_en && (wr_sel == SEL_W'(gi));

      ram_bank #(
        .DATA_W (DATA_W),
        .WORD_W (BANK_ADDR_W)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we[gi]),
        .waddr (wr_addr[BANK_ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (address[BANK_ADDR_W-1:0]),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  // Output mux: reads are masked to zero while the array is being cleared,
  // so stale or uninitialised words are never visible.
  always_comb begin
    out = '0;
    if (!busy) begin
      out = rd_word;
    end
  end

endmodule

// File: tb/tb_ram_banked_clr.sv
// Self-checking bench for ram_banked_clr: a driver issues one operation per
// cycle and pushes the expected response computed from a word-array model;
// a monitor pops and compares on the falling edge.
module tb_ram_banked_clr;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int BW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          busy;
  logic          drop;

  always #5 clk = ~clk;

  ram_banked_clr #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .BANK_ADDR_W (BW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (dout),
    .busy    (busy),
    .drop    (drop)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] out;
    logic          busy;
    logic          drop;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: word array, edges left until the array is free again,
  // and whether a rejected load must show on drop this cycle.
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left = DEPTH;
  bit            drop_pend = 1'b0;
  bit            in_reset = 1'b1;

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // Called just after a rising edge: drive, predict, advance the model.
  task automatic step(input bit ld, input bit clr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    exp_t e;
    bit   b;
    load    = ld;
    clear   = clr;
    address = a;
    din     = d;
    b       = in_reset || (clr_left > 0);
    e.addr  = a;
    e.out   = b ? '0 : mem_m[a];
    e.busy  = b;
    e.drop  = drop_pend;
    sb_q.push_back(e);
    if (ld || clr)
      $display("txn t=%0t load=%0b clear=%0b addr=%03h data=%04h exp_busy=%0b exp_out=%04h",
               $time, ld, clr, a, d, b, e.out);
    @(posedge clk);
    if (!in_reset) begin
      drop_pend = ld && b;
      if (b) begin
        clr_left = clr ? DEPTH : clr_left - 1;
      end else begin
        if (ld) mem_m[a] = d;
        if (clr) begin
          clr_left = DEPTH;
          model_zero();
        end
      end
    end
    #1;
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    in_reset  = 1'b1;
    clr_left  = DEPTH;
    drop_pend = 1'b0;
    model_zero();
  endtask

  task automatic release_reset();
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, a, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  // Run random reads until the model says the walk is over, bounded.
  task automatic walk_to_idle();
    int n = 0;
    while (clr_left > 0 && n < 2000) begin
      rd(AW'($urandom_range(0, DEPTH - 1)));
      n++;
    end
    if (clr_left > 0) begin
      errors++;
      $display("FAIL walk_bound: model still busy after %0d cycles, required idle", n);
    end
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks += 3;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL busy t=%0t addr=%03h got=%b exp=%b", $time, e.addr, busy, e.busy);
      end
      if (drop !== e.drop) begin
        errors++;
        $display("FAIL drop t=%0t addr=%03h got=%b exp=%b", $time, e.addr, drop, e.drop);
      end
      if (dout !== e.out) begin
        errors++;
        $display("FAIL out t=%0t addr=%03h got=%04h exp=%04h", $time, e.addr, dout, e.out);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    model_zero();
    @(posedge clk);
    #1;
    // Held in reset: busy=1, out=0, and a load must not produce drop.
    assert_reset();
    rd(9'h000);
    step(1'b1, 1'b0, 9'h003, 16'h1111);
    rd(9'h1FF);

    // 1 + 4: release, load at cycle 10 is dropped, walk runs 512 edges.
    release_reset();
    for (int k = 0; k < 12; k++) begin
      if (k == 10) step(1'b1, 1'b0, 9'h005, 16'hDEAD);
      else         rd(AW'(k));
    end
    walk_to_idle();
    rd(9'h000);
    rd(9'h1FF);
    rd(9'h0A5);
    rd(9'h005);

    // 2: plain writes; the write cycle itself still reads the old word.
    wr(9'h1A3, 16'hBEEF);
    wr(9'h1A4, 16'h1234);
    rd(9'h1A3);
    rd(9'h1A4);
    wr(9'h1A3, 16'hCAFE);
    rd(9'h1A3);

    // 3: bank boundaries and neighbours.
    wr(9'h007, 16'h0007);
    wr(9'h008, 16'h0008);
    wr(9'h1FF, 16'hFFFF);
    rd(9'h007);
    rd(9'h008);
    rd(9'h1FF);
    rd(9'h006);
    rd(9'h009);
    rd(9'h1FE);
    rd(9'h000);

    // 5: clear request wipes a filled word; out masked during the walk.
    wr(9'h010, 16'h5555);
    step(1'b0, 1'b1, 9'h010, '0);
    for (int k = 0; k < 20; k++) rd(9'h010);
    walk_to_idle();
    rd(9'h010);

    // Same-edge load and clear in IDLE: write lands, then is cleared.
    wr(9'h020, 16'h0AAA);
    step(1'b1, 1'b1, 9'h020, 16'h0BBB);
    rd(9'h020);
    walk_to_idle();
    rd(9'h020);

    // 6: reset mid-walk at clr_ptr=200, then a clear re-pulse mid-walk.
    wr(9'h030, 16'h7777);
    step(1'b0, 1'b1, 9'h030, '0);
    for (int k = 0; k < 200; k++) rd(9'h030);
    assert_reset();
    rd(9'h030);
    rd(9'h031);
    release_reset();
    for (int k = 0; k < 300; k++) rd(9'h030);
    step(1'b1, 1'b1, 9'h031, 16'h4444);
    walk_to_idle();
    rd(9'h030);
    rd(9'h031);

    // Randomised traffic with occasional clears and loads while busy.
    for (int k = 0; k < 800; k++) begin
      bit            ld;
      bit            cl;
      logic [AW-1:0] a;
      ld = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) a = AW'(9'h100 + $urandom_range(0, 15));
      else                           a = AW'($urandom_range(0, DEPTH - 1));
      step(ld, cl, a, DW'($urandom));
    end
    walk_to_idle();
    rd(9'h100);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
